ads5281_clkgen: RTL and testbench
=================================

// Module: ads5281_clkgen
// PURPOSE
// - Digital clock generator standing in for the ADS5281 ADC PLL in the ADC model/serializer path.
// - From one fast reference clock it produces three phase-aligned clocks:
//   - c0: frame/sample clock (ADCLK source).
//   - c1: 6x LCLK clock.
//   - c2: 12x serial-bit clock.
// - Reference must run at 2*C0_HALF times the c0 rate (24x with defaults). Adds lock indication.
// PARAMETERS
// - C0_HALF     12  c0 half-period, in inclk0 cycles.
// - C1_HALF      2  c1 half-period, in inclk0 cycles.
// - C2_HALF      1  c2 half-period, in inclk0 cycles.
// - LOCK_CYCLES  4  complete c0 periods after reset before locked asserts (>=1).
// PORTS
// - inclk0    in   1  reference clock; all logic on posedge.
// - areset_n  in   1  asynchronous active-low reset.
// - c0        out  1  frame clock, period 2*C0_HALF inclk0 cycles, 50% duty.
// - c1        out  1  LCLK clock, period 2*C1_HALF inclk0 cycles, 50% duty.
// - c2        out  1  bit clock, period 2*C2_HALF inclk0 cycles, 50% duty.
// - locked    out  1  high once outputs are stable; stays high until reset.
// BEHAVIOUR
// - One clock (inclk0) and one reset (areset_n). Reset is asynchronous and active-low; no other clock or reset.
// - Elaboration check, fatal if violated: C0_HALF % C1_HALF == 0, C0_HALF % C2_HALF == 0, all parameters >= 1.
// - Phase counter cnt, width $clog2(2*C0_HALF), sequence 0..2*C0_HALF-1 then wraps to 0.
// - Reset values: cnt = 2*C0_HALF-1; c0 = c1 = c2 = 0; locked = 0; period counter = 0.
// - On each posedge inclk0: cnt_n = (cnt == 2*C0_HALF-1) ? 0 : cnt+1; cnt <= cnt_n.
// - All outputs are registered from cnt_n, so they are glitch-free:
//   - c0 <= (cnt_n < C0_HALF).
//   - c1 <= ((cnt_n / C1_HALF) % 2 == 0).
//   - c2 <= ((cnt_n / C2_HALF) % 2 == 0).
// - Alignment: the first posedge after reset release gives cnt = 0, and c0, c1, c2 all rise together.
// - Every c0 rising edge coincides with rising edges of c1 and c2.
// - With defaults: c2 toggles on every posedge; c1 toggles every 2 posedges; c0 toggles every 12 posedges.
//   Ratios are c2 = 12x c0 and c1 = 6x c0.
// - Lock: a saturating period counter increments each time cnt_n == 0.
//   - locked <= 1 on the posedge where cnt_n == 0 and LOCK_CYCLES full periods have already completed.
//   - That is posedge number 1 + LOCK_CYCLES*2*C0_HALF after release (posedge 97 with defaults).
//   - locked is sticky until reset.
// - Reset mid-operation: all outputs drop to 0 asynchronously, immediately.
//   - After release, the sequence restarts exactly as from power-up, including relock.
// - Reset release has no synchronizer inside the block; the integrator releases reset away from the inclk0 edge.
// CONFIGURATION
// - ADS5281_CLKGEN_GATE_EN defined:
//   - c0, c1 and c2 are held 0 while locked == 0.
//   - Clocks first rise, aligned, on the same posedge that locked rises; that posedge is a c0 period start.
// - ADS5281_CLKGEN_GATE_EN undefined:
//   - Clocks run from the first posedge after reset release.
//   - locked is status only.
// TESTING
// - Reset held low, inclk0 toggling -> c0 = c1 = c2 = locked = 0 for the whole reset interval.
// - Release reset, defaults -> on posedge 1: c0 = c1 = c2 = 1.
//   - c2 low on posedge 2; c1 low on posedge 3; c0 low on posedge 13.
//   - c0 high again on posedge 25.
// - Defaults, 240 posedges -> exactly 10 c0, 60 c1 and 120 c2 rising edges, each coincident with a c0 rise where required.
// - Lock, defaults -> locked = 0 through posedge 96 and 1 from posedge 97 onward.
// - areset_n pulsed low at posedge 50 -> outputs 0 immediately; after release, same sequence as the first test, locked back to 0.
// - With ADS5281_CLKGEN_GATE_EN -> all clocks 0 until posedge 97, then c0, c1 and c2 rise together with locked.

Source files
------------

// File: rtl/ads5281_clkgen.sv
// Counter-based stand-in for the ADS5281 PLL: phase-aligned frame (c0), LCLK (c1) and bit (c2)
// clocks from inclk0, plus sticky lock. Define ADS5281_CLKGEN_GATE_EN to hold clocks low until lock.
module ads5281_clkgen #(
    parameter int unsigned C0_HALF     = 12,
    parameter int unsigned C1_HALF     = 2,
    parameter int unsigned C2_HALF     = 1,
    parameter int unsigned LOCK_CYCLES = 4
) (
    input  logic inclk0,
    input  logic areset_n,
    output logic c0,
    output logic c1,
    output logic c2,
    output logic locked
);

    localparam int unsigned Period = 2 * C0_HALF;
    // Width guards keep elaboration alive long enough for the parameter checks to report.
    localparam int unsigned CntW   = (C0_HALF < 1) ? 1 : $clog2(Period);
    localparam int unsigned PerW   = (LOCK_CYCLES < 1) ? 1 : $clog2(LOCK_CYCLES + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(Period - 1);
    localparam logic [PerW-1:0] PerMax = PerW'(LOCK_CYCLES);

    if (C0_HALF < 1 || C1_HALF < 1 || C2_HALF < 1 || LOCK_CYCLES < 1) begin : g_bad_zero
        $fatal(1, "ads5281_clkgen: all parameters must be >= 1");
    end else if ((C0_HALF % C1_HALF) != 0 || (C0_HALF % C2_HALF) != 0) begin : g_bad_ratio
        $fatal(1, "ads5281_clkgen: C0_HALF must be a multiple of C1_HALF and C2_HALF");
    end

    logic [CntW-1:0] cnt_q, cnt_d;
    logic [PerW-1:0] per_q, per_d;
    logic            c0_q, c0_d, c1_q, c1_d, c2_q, c2_d;
    logic            locked_q, locked_d;
    logic            period_start;
    logic            c0_raw, c1_raw, c2_raw;
    int unsigned     cnt_int;

    always_comb begin
        cnt_d        = (cnt_q == CntMax) ? '0 : cnt_q + CntW'(1);
        cnt_int      = 32'(cnt_d);
        period_start = (cnt_d == '0);

        per_d = per_q;
        if (period_start && per_q != PerMax) begin
            per_d = per_q + PerW'(1);
        end
        // per_q counts period starts seen; reaching PerMax at a new start means that many are done.
        locked_d = locked_q | (period_start && per_q == PerMax);

        c0_raw = cnt_int < C0_HALF;
        c1_raw = (cnt_int % (2 * C1_HALF)) < C1_HALF;
        c2_raw = (cnt_int % (2 * C2_HALF)) < C2_HALF;

`ifdef ADS5281_CLKGEN_GATE_EN
        c0_d = c0_raw & locked_d;
        c1_d = c1_raw & locked_d;
        c2_d = c2_raw & locked_d;
`else
        c0_d = c0_raw;
        c1_d = c1_raw;
        c2_d = c2_raw;
`endif
    end

    always_ff @(posedge inclk0 or negedge areset_n) begin
        if (!areset_n) begin
            cnt_q    <= CntMax;
            per_q    <= '0;
            c0_q     <= 1'b0;
            c1_q     <= 1'b0;
            c2_q     <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            per_q    <= per_d;
            c0_q     <= c0_d;
            c1_q     <= c1_d;
            c2_q     <= c2_d;
            locked_q <= locked_d;
        end
    end

    assign c0     = c0_q;
    assign c1     = c1_q;
    assign c2     = c2_q;
    assign locked = locked_q;

endmodule

// File: tb/tb_ads5281_clkgen.sv
// Self-checking bench for ads5281_clkgen with default parameters: hand-computed vectors plus a
// per-edge reference model, rise counting, lock timing and mid-run asynchronous reset.
module tb_ads5281_clkgen;

    logic inclk0   = 1'b0;
    logic areset_n = 1'b0;
    logic c0, c1, c2, locked;

    int errors = 0;
    int checks = 0;

    ads5281_clkgen #(
        .C0_HALF    (12),
        .C1_HALF    (2),
        .C2_HALF    (1),
        .LOCK_CYCLES(4)
    ) dut (
        .inclk0  (inclk0),
        .areset_n(areset_n),
        .c0      (c0),
        .c1      (c1),
        .c2      (c2),
        .locked  (locked)
    );

    always #5 inclk0 = ~inclk0;

    // exp = {c0, c1, c2, locked} sampled just after posedge number edge_n following release
    typedef struct {
        int         edge_n;
        logic [3:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [3:0] model(input int n);
        int   cnt;
        logic a, b, c, lk;
        cnt = (n - 1) % 24;
        lk  = (n >= 97);
        a   = (cnt < 12);
        b   = ((cnt % 4) < 2);
        c   = ((cnt % 2) == 0);
`ifdef ADS5281_CLKGEN_GATE_EN
        a = a & lk;
        b = b & lk;
        c = c & lk;
`endif
        return {a, b, c, lk};
    endfunction

    task automatic run_seq(input int n_edges, input bit do_counts);
        int         r0 = 0, r1 = 0, r2 = 0, vi = 0;
        logic [3:0] prev = 4'b0000;
        logic [3:0] cur;
        for (int n = 1; n <= n_edges; n++) begin
            @(posedge inclk0);
            #1;
            cur = {c0, c1, c2, locked};
            check($sformatf("model@%0d", n), 32'(cur), 32'(model(n)));
            if (vi < vecs.size() && vecs[vi].edge_n == n) begin
                check($sformatf("vec@%0d", n), 32'(cur), 32'(vecs[vi].exp));
                vi++;
            end
            if (cur[2] && !prev[2]) r1++;
            if (cur[1] && !prev[1]) r2++;
            if (cur[3] && !prev[3]) begin
                r0++;
                check($sformatf("c0_rise_align@%0d", n), 32'(cur[2:1] & ~prev[2:1]), 32'd3);
            end
            prev = cur;
        end
        if (do_counts) begin
`ifdef ADS5281_CLKGEN_GATE_EN
            check("c0_rises", 32'(r0), 32'd6);
            check("c1_rises", 32'(r1), 32'd36);
            check("c2_rises", 32'(r2), 32'd72);
`else
            check("c0_rises", 32'(r0), 32'd10);
            check("c1_rises", 32'(r1), 32'd60);
            check("c2_rises", 32'(r2), 32'd120);
`endif
        end
    endtask

    task automatic check_reset_hold(input string tag, input int n_cycles);
        for (int i = 0; i < n_cycles; i++) begin
            @(posedge inclk0);
            #1;
            check($sformatf("%s_hold%0d", tag, i), 32'({c0, c1, c2, locked}), 32'd0);
        end
    endtask

    initial begin
`ifdef ADS5281_CLKGEN_GATE_EN
        vecs.push_back('{1,  4'b0000});
        vecs.push_back('{2,  4'b0000});
        vecs.push_back('{25, 4'b0000});
        vecs.push_back('{96, 4'b0000});
        vecs.push_back('{97, 4'b1111});
        vecs.push_back('{98, 4'b1101});
        vecs.push_back('{99, 4'b1011});
        vecs.push_back('{109, 4'b0111});
`else
        vecs.push_back('{1,  4'b1110});
        vecs.push_back('{2,  4'b1100});
        vecs.push_back('{3,  4'b1010});
        vecs.push_back('{4,  4'b1000});
        vecs.push_back('{5,  4'b1110});
        vecs.push_back('{12, 4'b1000});
        vecs.push_back('{13, 4'b0110});
        vecs.push_back('{24, 4'b0000});
        vecs.push_back('{25, 4'b1110});
        vecs.push_back('{96, 4'b0000});
        vecs.push_back('{97, 4'b1111});
        vecs.push_back('{98, 4'b1101});
`endif

        check_reset_hold("por", 5);
        @(negedge inclk0);
        areset_n = 1'b1;
        run_seq(240, 1'b1);

        // Mid-run reset after lock: outputs (including locked) must drop without a clock edge.
        @(negedge inclk0);
        areset_n = 1'b0;
        #1;
        check("locked_reset_async", 32'({c0, c1, c2, locked}), 32'd0);
        check_reset_hold("rst1", 2);
        @(negedge inclk0);
        areset_n = 1'b1;

        run_seq(50, 1'b0);
        #2;
        areset_n = 1'b0;
        #1;
        check("edge50_reset_async", 32'({c0, c1, c2, locked}), 32'd0);
        check_reset_hold("rst2", 3);
        @(negedge inclk0);
        areset_n = 1'b1;
        run_seq(240, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
